// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-word memory client feeding a prefetch FIFO for the decoder.
// Latency: a word acked at edge N is at the FIFO head (instr_valid) after edge N; 1 word/cycle sustained.
// Backpressure: decoder stall fills the FIFO, then requests pause until a pop frees an entry.
module instruction_fetch #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] RESET_PC   = 10'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic        mem_en,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_di,
    output logic        mem_we,
    output logic [3:0]  mem_bank_select,
    output logic        mem_burst_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_do,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [9:0]  instr_pc
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    fetch_pc_q, fetch_pc_d;
    logic          mem_en_q, mem_en_d;
    logic [9:0]    mem_addr_q, mem_addr_d;
    logic [9:0]    redirect_pc_aligned;

    logic [31:0]   word_q [FIFO_DEPTH];
    logic [9:0]    pc_q   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_after;
    logic          push;
    logic          pop;

    assign mem_di          = 32'd0;
    assign mem_we          = 1'b0;
    assign mem_bank_select = 4'b1111;
    assign mem_burst_en    = 1'b0;
    assign mem_en          = mem_en_q;
    assign mem_addr        = mem_addr_q;

    assign instr_valid = (count_q != '0);
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];

    assign redirect_pc_aligned = redirect_pc & 10'h3FC;

    // A redirect flushes the FIFO, so it suppresses both the push of an acked word and a pop.
    assign push        = (state_q == REQ) & mem_ack & ~redirect;
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign count_after = count_q + CW'(push) - CW'(pop);

    // Next-state logic: request issue, hold-until-ack, and redirect handling.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                end else if (count_after < DEPTH_C) begin
                    state_d    = REQ;
                    mem_en_d   = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                    if (mem_ack) begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                    end else begin
                        // Keep the controller transaction alive; its data is discarded in DROP.
                        state_d = DROP;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + 10'd4;
                    if (count_after < DEPTH_C) begin
                        mem_addr_d = fetch_pc_q + 10'd4;
                    end else begin
                        state_d  = IDLE;
                        mem_en_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_aligned;
                end
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // State, fetch address and registered memory request outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_en_q   <= 1'b0;
            mem_addr_q <= 10'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Prefetch FIFO storage and pointers; the head entry drives the decoder outputs directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_q[i] <= 32'd0;
                pc_q[i]   <= 10'd0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                word_q[wr_ptr_q] <= mem_do;
                pc_q[wr_ptr_q]   <= fetch_pc_q;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_after;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: architectural stream model plus memory-protocol checks.
// Each step drives inputs on the falling edge and samples outputs there, away from the rising edge.
// The memory responder acks only while mem_en is high; data is a fixed function of the address.
module tb_instruction_fetch;

    localparam int         DEPTH  = 4;
    localparam logic [9:0] RST_PC = 10'd0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_di;
    logic        mem_we;
    logic [3:0]  mem_bank_select;
    logic        mem_burst_en;
    logic        mem_ack;
    logic [31:0] mem_do;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [9:0]  instr_pc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the decoder must see consecutive words starting at exp_pc,
    // restarting at the aligned redirect target after every redirect.
    int         exp_pc;
    int         accepted;
    int         n_acks;
    int         acc_log[$];
    logic       prev_en;
    logic       prev_ack;
    logic [9:0] prev_addr;

    always #5 clk = ~clk;

    instruction_fetch #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_di          (mem_di),
        .mem_we          (mem_we),
        .mem_bank_select (mem_bank_select),
        .mem_burst_en    (mem_burst_en),
        .mem_ack         (mem_ack),
        .mem_do          (mem_do),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    function automatic logic [31:0] word_of(input logic [9:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive at the falling edge, check, advance to the next falling edge.
    task automatic step(input logic ack, input logic rdy, input logic redir, input logic [9:0] rpc);
        logic mack;
        logic acc;
        mack        = ack & mem_en;
        mem_ack     = mack;
        mem_do      = mack ? word_of(mem_addr) : $urandom;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;

        n_tests++;
        if (mem_we !== 1'b0 || mem_di !== 32'd0 || mem_bank_select !== 4'hF || mem_burst_en !== 1'b0) begin
            n_fail++;
            $display("FAIL const_outputs: got we=%b di=%h bs=%h burst=%b, want we=0 di=0 bs=f burst=0",
                     mem_we, mem_di, mem_bank_select, mem_burst_en);
        end
        if (prev_en && !prev_ack) begin
            n_tests++;
            if (mem_en !== 1'b1 || mem_addr !== prev_addr) begin
                n_fail++;
                $display("FAIL req_hold: got en=%b addr=%h, want en=1 addr=%h", mem_en, mem_addr, prev_addr);
            end
        end
        acc = (instr_valid === 1'b1) && rdy && !redir;
        if (acc) begin
            n_tests++;
            if (instr_pc !== 10'(exp_pc) || instr !== word_of(10'(exp_pc))) begin
                n_fail++;
                $display("FAIL stream_word: got pc=%h instr=%h, want pc=%h instr=%h",
                         instr_pc, instr, 10'(exp_pc), word_of(10'(exp_pc)));
            end
            acc_log.push_back(int'(instr_pc));
            exp_pc = (exp_pc + 4) % 1024;
            accepted++;
        end
        if (mack) n_acks++;
        prev_en   = mem_en;
        prev_ack  = mack;
        prev_addr = mem_addr;

        @(posedge clk);
        @(negedge clk);
        if (redir) begin
            exp_pc = int'(rpc & 10'h3FC);
            n_tests++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_flush: got instr_valid=%b, want 0", instr_valid);
            end
        end
        mem_ack  = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 10'd0;
        mem_ack     = 1'b0;
        mem_do      = 32'd0;
        instr_ready = 1'b0;
        prev_en     = 1'b0;
        prev_ack    = 1'b0;
        prev_addr   = 10'd0;
        accepted    = 0;
        n_acks      = 0;
        #12;
        n_tests++;
        if ({mem_en, mem_addr, instr_valid, instr, instr_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b addr=%h vld=%b instr=%h pc=%h, want all 0",
                     mem_en, mem_addr, instr_valid, instr, instr_pc);
        end
        n_tests++;
        if (mem_we !== 1'b0 || mem_di !== 32'd0 || mem_bank_select !== 4'hF || mem_burst_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_consts: got we=%b di=%h bs=%h burst=%b, want 0 0 f 0",
                     mem_we, mem_di, mem_bank_select, mem_burst_en);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc  = int'(RST_PC);
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== RST_PC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_request: got en=%b addr=%h vld=%b, want en=1 addr=%h vld=0",
                     mem_en, mem_addr, instr_valid, RST_PC);
        end
    endtask

    task automatic test_stream();
        int a0;
        a0 = accepted;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (accepted - a0 < 37) begin
            n_fail++;
            $display("FAIL stream_throughput: got %0d words in 40 cycles, want >= 37", accepted - a0);
        end
    endtask

    task automatic test_backpressure();
        int k0;
        step(1'b1, 1'b0, 1'b1, 10'h040);
        k0 = n_acks;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 10'd0);
        n_tests++;
        if (n_acks - k0 != DEPTH || mem_en !== 1'b0 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_stop: got acks=%0d en=%b vld=%b, want acks=%0d en=0 vld=1",
                     n_acks - k0, mem_en, instr_valid, DEPTH);
        end
        step(1'b1, 1'b1, 1'b0, 10'd0);
        k0 = n_acks;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 10'd0);
        n_tests++;
        if (n_acks - k0 != 1 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL one_pop_one_req: got acks=%0d en=%b, want acks=1 en=0", n_acks - k0, mem_en);
        end
    endtask

    task automatic test_redirect_drop();
        logic [9:0] old_addr;
        int         a0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
        old_addr = mem_addr;
        step(1'b0, 1'b1, 1'b1, 10'h104);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (mem_en !== 1'b1 || mem_addr !== old_addr) begin
                n_fail++;
                $display("FAIL drop_hold: got en=%b addr=%h, want en=1 addr=%h", mem_en, mem_addr, old_addr);
            end
            step(1'b0, 1'b1, 1'b0, 10'd0);
        end
        step(1'b1, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (mem_en !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ack: got en=%b vld=%b, want en=0 vld=0", mem_en, instr_valid);
        end
        step(1'b0, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 10'h104) begin
            n_fail++;
            $display("FAIL drop_restart: got en=%b addr=%h, want en=1 addr=104", mem_en, mem_addr);
        end
        a0 = accepted;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (accepted - a0 < 4) begin
            n_fail++;
            $display("FAIL drop_resume: got %0d words, want >= 4", accepted - a0);
        end
    endtask

    task automatic test_redirect_with_ack();
        step(1'b1, 1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 1'b1, 10'h107);
        n_tests++;
        if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_ack_idle: got en=%b, want 0", mem_en);
        end
        step(1'b0, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== 10'h104) begin
            n_fail++;
            $display("FAIL redir_ack_restart: got en=%b addr=%h, want en=1 addr=104", mem_en, mem_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
    endtask

    task automatic test_wrap();
        int want[4];
        want = '{1016, 1020, 0, 4};
        step(1'b1, 1'b1, 1'b1, 10'd1016);
        acc_log.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (acc_log.size() <= i || acc_log[i] != want[i]) begin
                n_fail++;
                $display("FAIL wrap_pc[%0d]: got %0d, want %0d", i,
                         (acc_log.size() > i) ? acc_log[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b1, 10'h200);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 10'd0);
        n_tests++;
        if (instr_valid !== 1'b1 || mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got vld=%b en=%b, want vld=1 en=1", instr_valid, mem_en);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_en, mem_addr, instr_valid, instr, instr_pc} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b addr=%h vld=%b instr=%h pc=%h, want all 0",
                     mem_en, mem_addr, instr_valid, instr, instr_pc);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        exp_pc   = int'(RST_PC);
        prev_en  = 1'b0;
        prev_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b1 || mem_addr !== RST_PC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_restart: got en=%b addr=%h vld=%b, want en=1 addr=%h vld=0",
                     mem_en, mem_addr, instr_valid, RST_PC);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
    endtask

    task automatic test_random();
        int a0;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), 10'($urandom));
        end
        a0 = accepted;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 10'd0);
        n_tests++;
        if (accepted - a0 < 15) begin
            n_fail++;
            $display("FAIL random_drain: got %0d words in 20 cycles, want >= 15", accepted - a0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_with_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
